// File: rtl/avmm_decode_mux.sv
// Avalon-MM host-to-NUM_TARGETS decode mux: base/mask windows, one outstanding
// transaction, error completion for unmapped accesses. `AVMM_MUX_TIMEOUT_EN adds a stall abort.

module avmm_win_match #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    assign hit = (addr & MASK) == BASE;
endmodule

module avmm_decode_mux #(
    parameter int                            NUM_TARGETS    = 4,
    parameter int                            ADDR_W         = 32,
    parameter int                            DATA_W         = 32,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_BASE       = '0,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_MASK       = '0,
    parameter int                            TIMEOUT_CYCLES = 1023,
    parameter logic [DATA_W-1:0]             ERR_RDATA      = DATA_W'(32'hDEAD_DEAD)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ADDR_W-1:0]             s_address,
    input  logic                          s_read,
    input  logic                          s_write,
    input  logic [DATA_W-1:0]             s_writedata,
    input  logic [DATA_W/8-1:0]           s_byteenable,
    output logic [DATA_W-1:0]             s_readdata,
    output logic                          s_readdatavalid,
    output logic                          s_waitrequest,
    output logic                          s_error,
    output logic [ADDR_W-1:0]             m_address,
    output logic [DATA_W-1:0]             m_writedata,
    output logic [DATA_W/8-1:0]           m_byteenable,
    output logic [NUM_TARGETS-1:0]        m_read,
    output logic [NUM_TARGETS-1:0]        m_write,
    input  logic [NUM_TARGETS*DATA_W-1:0] m_readdata,
    input  logic [NUM_TARGETS-1:0]        m_readdatavalid,
    input  logic [NUM_TARGETS-1:0]        m_waitrequest
);
    localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [1:0] {IDLE, FWD, RDW, ERR} state_t;

    state_t                               state_q, state_d;
    logic   [SEL_W-1:0]                   sel_q, hit_idx;
    logic                                 op_wr_q, hit_any, req;
    logic   [NUM_TARGETS-1:0]             hit;
    logic   [NUM_TARGETS-1:0][DATA_W-1:0] m_rd_v;
    logic                                 tmo, tmo_pre, err_wr, err_rd;

    if (NUM_TARGETS < 1 || NUM_TARGETS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("avmm_decode_mux: NUM_TARGETS must be 1..16 and TIMEOUT_CYCLES >= 2");
    end

    assign m_address    = s_address;
    assign m_writedata  = s_writedata;
    assign m_byteenable = s_byteenable;
    assign m_rd_v       = m_readdata;
    assign req          = s_read | s_write;

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_win
        avmm_win_match #(
            .ADDR_W (ADDR_W),
            .BASE   (TGT_BASE[i*ADDR_W +: ADDR_W]),
            .MASK   (TGT_MASK[i*ADDR_W +: ADDR_W])
        ) u_win (
            .addr (s_address),
            .hit  (hit[i])
        );
    end

    // Scan high to low so the lowest matching window is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

`ifdef AVMM_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Clears on every state change, so both FWD and RDW start counting from zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tmo_cnt <= '0;
        else if ((state_q != FWD && state_q != RDW) || state_d != state_q)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    assign tmo     = tmo_cnt == CNT_W'(TIMEOUT_CYCLES);
    assign tmo_pre = tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign tmo     = 1'b0;
    assign tmo_pre = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        s_waitrequest = 1'b1;
        m_read        = '0;
        m_write       = '0;
        err_wr        = 1'b0;
        err_rd        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = hit_any ? FWD : ERR;
                    err_wr  = !hit_any && s_write;
                end
            end
            FWD: begin
                if (tmo) begin
                    s_waitrequest = 1'b0;
                    err_rd        = !op_wr_q;
                    state_d       = IDLE;
                end else begin
                    m_write[sel_q] = op_wr_q;
                    m_read[sel_q]  = !op_wr_q;
                    s_waitrequest  = m_waitrequest[sel_q];
                    // Write abort error must already be registered when the abort cycle arrives.
                    err_wr         = op_wr_q && tmo_pre && m_waitrequest[sel_q];
                    if (!m_waitrequest[sel_q])
                        state_d = op_wr_q ? IDLE : RDW;
                end
            end
            RDW: begin
                if (m_readdatavalid[sel_q])
                    state_d = IDLE;
                else if (tmo) begin
                    err_rd  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                s_waitrequest = 1'b0;
                err_rd        = !op_wr_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            op_wr_q         <= 1'b0;
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
            s_error         <= 1'b0;
        end else begin
            state_q         <= state_d;
            s_readdatavalid <= 1'b0;
            s_error         <= 1'b0;
            if (state_q == IDLE && req) begin
                sel_q   <= hit_idx;
                op_wr_q <= s_write;
            end
            if (err_wr)
                s_error <= 1'b1;
            if (err_rd) begin
                s_readdata      <= ERR_RDATA;
                s_readdatavalid <= 1'b1;
                s_error         <= 1'b1;
            end else if (state_q == RDW && m_readdatavalid[sel_q]) begin
                s_readdata      <= m_rd_v[sel_q];
                s_readdatavalid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avmm_decode_mux.sv
// Directed bench for avmm_decode_mux: behavioural targets with programmable wait
// states / read latency, per-transaction latency and data checks.

module tb_avmm_decode_mux;
    localparam int NT = 4, AW = 32, DW = 32, BW = DW / 8, TMO = 8;
    localparam logic [NT*AW-1:0] BASE = {32'h0000_4000, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000};
    localparam logic [NT*AW-1:0] MASK = {32'hFFFF_F000, 32'h0000_0F00, 32'hFFFF_FE00, 32'hFFFF_FF00};

    logic                   clk = 1'b0, rstn = 1'b0;
    logic [AW-1:0]          s_address = '0;
    logic                   s_read = 1'b0, s_write = 1'b0;
    logic [DW-1:0]          s_writedata = '0;
    logic [BW-1:0]          s_byteenable = '0;
    logic [DW-1:0]          s_readdata;
    logic                   s_readdatavalid, s_waitrequest, s_error;
    logic [AW-1:0]          m_address;
    logic [DW-1:0]          m_writedata;
    logic [BW-1:0]          m_byteenable;
    logic [NT-1:0]          m_read, m_write, m_readdatavalid, m_waitrequest;
    logic [NT-1:0][DW-1:0]  rd_val;
    logic [NT-1:0]          stall = '0, inj_rdv = '0;
    int                     ws [NT];
    int                     lat [NT];
    int                     wcnt [NT];
    int                     lcnt [NT];
    int                     n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    avmm_decode_mux #(
        .NUM_TARGETS    (NT),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TGT_BASE       (BASE),
        .TGT_MASK       (MASK),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (32'hDEAD_DEAD)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_waitrequest   (s_waitrequest),
        .s_error         (s_error),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_readdata      (rd_val),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest)
    );

    // Target model: ws[i] wait cycles per command, read data lat[i] cycles after accept.
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            m_waitrequest[i]   = stall[i] || (wcnt[i] < ws[i]);
            m_readdatavalid[i] = (lcnt[i] == 1) || inj_rdv[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (m_read[i] || m_write[i])
                wcnt[i] <= m_waitrequest[i] ? wcnt[i] + 1 : 0;
            else
                wcnt[i] <= 0;
            if (m_read[i] && !m_waitrequest[i])
                lcnt[i] <= lat[i];
            else if (lcnt[i] > 0)
                lcnt[i] <= lcnt[i] - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one request at cycle 0 (called just after a rising edge) and records
    // the acceptance and response cycles relative to it.
    task automatic xfer(input string tag, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int e_acc, input int e_rsp,
                        input logic [NT-1:0] e_cmd, input int e_ncmd,
                        input logic [DW-1:0] e_rd, input bit e_err);
        int            cyc = 0, acc = -1, rsp = -1, ncmd = 0;
        logic [NT-1:0] cmd = '0;
        logic [DW-1:0] rd = '0;
        logic [AW-1:0] cap_a = '0;
        logic [DW-1:0] cap_d = '0;
        bit            err = 1'b0;
        s_address   = addr;
        s_writedata = wdata;
        s_byteenable = '1;
        s_write     = wr;
        s_read      = !wr;
        while (cyc < 64 && (wr ? acc < 0 : rsp < 0)) begin
            @(negedge clk);
            if (cyc == 0) begin
                cap_a = m_address;
                cap_d = m_writedata;
            end
            if ((m_read | m_write) != '0) begin
                ncmd++;
                cmd |= m_read | m_write;
            end
            if (acc < 0 && !s_waitrequest) begin
                acc = cyc;
                if (wr) err = s_error;
            end
            if (s_readdatavalid) begin
                rsp = cyc;
                rd  = s_readdata;
                err = s_error;
            end
            @(posedge clk); #1;
            if (acc >= 0) begin
                s_read  = 1'b0;
                s_write = 1'b0;
            end
            cyc++;
        end
        s_read  = 1'b0;
        s_write = 1'b0;
        chk({tag, ".acc"}, acc, e_acc);
        chk({tag, ".rsp"}, rsp, e_rsp);
        chk({tag, ".cmd"}, cmd, e_cmd);
        chk({tag, ".ncmd"}, ncmd, e_ncmd);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".pass"}, {cap_a, cap_d}, {addr, wdata});
        if (!wr) chk({tag, ".rdata"}, rd, e_rd);
        @(negedge clk);
        chk({tag, ".post"}, {m_read | m_write, s_readdatavalid, s_error}, '0);
        @(posedge clk); #1;
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(tag, s_readdatavalid, 1'b0);
        end
        @(posedge clk); #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".wreq"}, s_waitrequest, 1'b1);
        chk({tag, ".cmd"}, {m_read, m_write}, '0);
        chk({tag, ".resp"}, {s_readdatavalid, s_error, s_readdata}, '0);
    endtask

    task automatic rst_pulse(input string tag);
        rstn    = 1'b0;
        s_read  = 1'b0;
        s_write = 1'b0;
        #1;
        rst_chk(tag);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < NT; i++) begin
            ws[i] = 0; lat[i] = 1; wcnt[i] = 0; lcnt[i] = 0;
        end
        rd_val = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_chk("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        xfer("wr_t2", 1, 32'h200, 32'h1234_5678, 1, -1, 4'b0100, 1, '0, 0);
        ws[0] = 3; lat[0] = 2;
        xfer("rd_t0_ws3", 0, 32'h10, '0, 4, 7, 4'b0001, 4, 32'hA0A0_0000, 0);
        xfer("rd_unmap", 0, 32'hF000, '0, 1, 2, 4'b0000, 0, 32'hDEAD_DEAD, 1);
        ws[0] = 0; lat[0] = 1;
        xfer("rd_ovl", 0, 32'h40, '0, 1, 3, 4'b0001, 1, 32'hA0A0_0000, 0);
        ws[1] = 1;
        xfer("rd_t1", 0, 32'h180, '0, 2, 4, 4'b0010, 2, 32'hB1B1_0001, 0);
        xfer("wr_unmap", 1, 32'hF000, 32'h0000_CAFE, 1, -1, 4'b0000, 0, '0, 1);
        ws[3] = 2;
        xfer("wr_t3", 1, 32'h4008, 32'h0BAD_F00D, 3, -1, 4'b1000, 3, '0, 0);
        xfer("wr_t2_alias", 1, 32'h1200, 32'h5555_AAAA, 1, -1, 4'b0100, 1, '0, 0);

        inj_rdv = 4'b1110; lat[0] = 3;
        xfer("rd_noise", 0, 32'h20, '0, 1, 5, 4'b0001, 1, 32'hA0A0_0000, 0);
        inj_rdv = 4'b1111;
        idle_chk("idle_rdv", 3);
        inj_rdv = '0; lat[0] = 1;

`ifdef AVMM_MUX_TIMEOUT_EN
        stall[2] = 1'b1;
        xfer("rd_tmo_fwd", 0, 32'h200, '0, 9, 10, 4'b0100, 8, 32'hDEAD_DEAD, 1);
        xfer("wr_tmo_fwd", 1, 32'h200, 32'h0000_0077, 9, -1, 4'b0100, 8, '0, 1);
        stall[2] = 1'b0;
        inj_rdv[2] = 1'b1;
        idle_chk("late_fwd", 2);
        inj_rdv[2] = 1'b0;
        lat[0] = 20;
        xfer("rd_tmo_rdw", 0, 32'h0, '0, 1, 11, 4'b0001, 1, 32'hDEAD_DEAD, 1);
        idle_chk("late_rdw", 15);
        lat[0] = 1;
`else
        stall[2]  = 1'b1;
        s_address = 32'h200;
        s_read    = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("stall.wreq", s_waitrequest, 1'b1);
        chk("stall.mrd", m_read, 4'b0100);
        stall[2] = 1'b0;
        @(posedge clk); #1;
        s_read = 1'b0;
        n = 0;
        while (n < 10 && !s_readdatavalid) begin
            @(negedge clk);
            n++;
        end
        chk("stall.rdv", s_readdatavalid, 1'b1);
        chk("stall.rdata", s_readdata, 32'hC2C2_0002);
        @(posedge clk); #1;
`endif

        // Async reset while a stalled command is on the bus.
        stall[1]  = 1'b1;
        s_address = 32'h180;
        s_read    = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_fwd.pre", m_read, 4'b0010);
        rst_pulse("rst_fwd");
        stall[1] = 1'b0;

        // Async reset clears a registered s_error mid-cycle.
        s_address = 32'hF000;
        s_write   = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_err.pre", s_error, 1'b1);
        rst_pulse("rst_err");

        // Async reset during RDW; the stale target data must not surface.
        lat[0]    = 10;
        s_address = 32'h0;
        s_read    = 1'b1;
        @(posedge clk); #1;
        s_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rdw.pre", {s_waitrequest, m_read}, {1'b1, 4'b0000});
        rst_pulse("rst_rdw");
        idle_chk("rst_rdw.late", 12);
        lat[0] = 1;
        xfer("rd_after_rst", 0, 32'h8, '0, 1, 3, 4'b0001, 1, 32'hA0A0_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
